// File: rtl/stream_out_pkg.sv
// Shared definitions for the stream_out_fifo capture stage.
package stream_out_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_CNT_W  = 8;

  typedef logic [7:0] byte_t;

  // Pointer width needed to address a FIFO of the given depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_out_fifo_mem_2p.sv
// Register-array storage for the FIFO: synchronous write, asynchronous read,
// cleared to zero on reset so an empty FIFO presents a known out_data.
module fifo_mem_2p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update: zero every entry on reset, otherwise write one entry when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_out_fifo.sv
// First-word-fall-through capture FIFO for the top_level byte stream, with
// occupancy, sticky overflow and a saturating dropped-byte counter.
module stream_out_fifo
  import stream_out_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic full_s;
  logic empty_s;
  logic pop_s;
  logic push_s;
  logic drop_s;
  logic [DATA_W-1:0] rdata_s;

  assign full_s  = (level_q == LW'(DEPTH));
  assign empty_s = (level_q == {LW{1'b0}});
  assign pop_s   = !empty_s && out_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_s  = in_valid && (!full_s || pop_s);
  assign drop_s  = in_valid && full_s && !pop_s;

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_s),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata_s)
  );

  // Next-state for pointers, occupancy, overflow flag and drop counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + {{(LW-1){1'b0}}, push_s} - {{(LW-1){1'b0}}, pop_s};
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // A drop in the clearing cycle keeps the flag set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    // The clear restarts counting, and counts a drop from the same cycle.
    if (clr_ovf) begin
      drop_cnt_d = drop_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      level_q    <= {LW{1'b0}};
      overflow_q <= 1'b0;
      drop_cnt_q <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_data  = rdata_s;
  assign out_valid = !empty_s;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
